// File: rtl/changed_check_mon.sv
// changed_check_mon: per-channel change/stability/idle-window monitor with sticky errors and saturating totals
module changed_check_mon #(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 1,
   parameter int IDLE_MAX = 4,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [2*NUM_CH-1:0]       mode,
   input  logic [NUM_CH*WIDTH-1:0]   sig,
   input  logic                      clr_err,
   output logic [NUM_CH-1:0]         changed,
   output logic [NUM_CH-1:0]         fail,
   output logic [NUM_CH-1:0]         err_sticky,
   output logic [CNT_W-1:0]          pass_cnt,
   output logic [CNT_W-1:0]          fail_cnt
);
   localparam int IW = $clog2(IDLE_MAX + 1);
   localparam int SW = CNT_W + $clog2(NUM_CH + 1) + 1;
   localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});
   localparam logic [IW-1:0] LAST = IW'(IDLE_MAX - 1);
   logic [NUM_CH*WIDTH-1:0] prev;
   logic [NUM_CH-1:0][1:0] md, md_q;
   logic [NUM_CH-1:0] armed, act, chg, pass_n, fail_n;
   logic [NUM_CH-1:0][IW-1:0] idle_q, idle_e, idle_n;
   logic [SW-1:0] pass_sum, fail_sum;
   assign md = mode;
   always_comb begin
      act = armed & {NUM_CH{en}};
      for (int i = 0; i < NUM_CH; i++) begin
         chg[i]    = act[i] && sig[i*WIDTH +: WIDTH] != prev[i*WIDTH +: WIDTH];
         // a mode switch restarts the idle window before this edge is evaluated
         idle_e[i] = md[i] != md_q[i] ? '0 : idle_q[i];
         pass_n[i] = act[i] && (md[i] == 2'b10 ? !chg[i] : md[i] != 2'b00 && chg[i]);
         fail_n[i] = act[i] && (md[i] == 2'b01 ? !chg[i] :
                                md[i] == 2'b10 ? chg[i] :
                                md[i] == 2'b11 && !chg[i] && idle_e[i] == LAST);
         idle_n[i] = act[i] && md[i] == 2'b11 && !chg[i] && idle_e[i] != LAST ? idle_e[i] + 1'b1 : '0;
      end
      pass_sum = (clr_err ? '0 : SW'(pass_cnt)) + SW'($countones(pass_n));
      fail_sum = (clr_err ? '0 : SW'(fail_cnt)) + SW'($countones(fail_n));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         prev       <= '0;
         md_q       <= '0;
         armed      <= '0;
         idle_q     <= '0;
         changed    <= '0;
         fail       <= '0;
         err_sticky <= '0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
      end else begin
         if (en) prev <= sig;
         md_q       <= md;
         armed      <= {NUM_CH{en}};
         idle_q     <= idle_n;
         changed    <= chg;
         fail       <= fail_n;
         err_sticky <= (clr_err ? '0 : err_sticky) | fail_n;
         pass_cnt   <= pass_sum > CMAX ? '1 : pass_sum[CNT_W-1:0];
         fail_cnt   <= fail_sum > CMAX ? '1 : fail_sum[CNT_W-1:0];
      end
   end
endmodule

// File: tb/tb_changed_check_mon.sv
// tb_changed_check_mon: directed stimulus, behavioural model compare each cycle, literal pins on key results
module tb_changed_check_mon;
   localparam int N = 4, W = 2, IM = 4;
   logic clk = 0, rst, en, clr_err;
   logic [2*N-1:0] mode;
   logic [N*W-1:0] sig;
   logic [N-1:0] changed, fail, err_sticky, changed_s, fail_s, err_sticky_s;
   logic [15:0] pass_cnt, fail_cnt;
   logic [3:0] pass_cnt_s, fail_cnt_s;
   int checks = 0, errors = 0;

   changed_check_mon #(.NUM_CH(N), .WIDTH(W), .IDLE_MAX(IM), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sig(sig), .clr_err(clr_err),
      .changed(changed), .fail(fail), .err_sticky(err_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt));
   changed_check_mon #(.NUM_CH(N), .WIDTH(W), .IDLE_MAX(IM), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sig(sig), .clr_err(clr_err),
      .changed(changed_s), .fail(fail_s), .err_sticky(err_sticky_s), .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int x, input int w);
      return x > (1 << w) - 1 ? (1 << w) - 1 : x;
   endfunction

   // model: last sample, armed flag and consecutive idle samples per channel; totals kept unbounded
   int m_prev[N], m_idle[N], m_mprev[N];
   bit m_armed[N];
   bit [N-1:0] e_chg, e_fail, e_sticky;
   int tp, tf;

   always @(posedge clk) begin
      int s, md;
      bit c, p, f;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_prev[i] = 0; m_idle[i] = 0; m_mprev[i] = 0; m_armed[i] = 0;
         end
         e_chg = 0; e_fail = 0; e_sticky = 0; tp = 0; tf = 0;
      end else begin
         if (clr_err) begin
            e_sticky = 0; tp = 0; tf = 0;
         end
         for (int i = 0; i < N; i++) begin
            s = int'(sig[i*W +: W]);
            md = int'(mode[2*i +: 2]);
            c = 0; p = 0; f = 0;
            if (md != m_mprev[i]) m_idle[i] = 0;
            m_mprev[i] = md;
            if (en && m_armed[i]) begin
               c = s != m_prev[i];
               if (md == 1) begin p = c; f = !c; end
               else if (md == 2) begin p = !c; f = c; end
               else if (md == 3) begin
                  if (c) begin p = 1; m_idle[i] = 0; end
                  else if (m_idle[i] == IM - 1) begin f = 1; m_idle[i] = 0; end
                  else m_idle[i]++;
               end
               if (md != 3) m_idle[i] = 0;
            end else m_idle[i] = 0;
            e_chg[i] = c; e_fail[i] = f; e_sticky[i] = e_sticky[i] | f;
            tp += int'(p); tf += int'(f);
            if (en) begin m_prev[i] = s; m_armed[i] = 1; end
            else m_armed[i] = 0;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      chk("changed", changed, e_chg);
      chk("fail", fail, e_fail);
      chk("err_sticky", err_sticky, e_sticky);
      chk("pass_cnt", pass_cnt, sat(tp, 16));
      chk("fail_cnt", fail_cnt, sat(tf, 16));
      chk("changed_s", changed_s, e_chg);
      chk("fail_s", fail_s, e_fail);
      chk("err_sticky_s", err_sticky_s, e_sticky);
      chk("pass_cnt_s", pass_cnt_s, sat(tp, 4));
      chk("fail_cnt_s", fail_cnt_s, sat(tf, 4));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1; en = 0; clr_err = 0; mode = 0; sig = 0;
      tick(); sig = '1; tick();
      chk("rst_changed", changed, 0);
      chk("rst_fail", fail, 0);
      chk("rst_sticky", err_sticky, 0);
      chk("rst_fail_cnt", fail_cnt, 0);
      rst = 0; en = 1; mode = 8'h55; sig = 0;
      for (int k = 0; k < 10; k++) begin
         sig[0 +: W] = W'(k % 2);
         tick();
         if (k == 0) begin
            chk("unarmed_changed", changed, 0);
            chk("unarmed_fail", fail, 0);
         end
      end
      chk("mc_fail_vec", fail, 4'b1110);
      chk("mc_pass_cnt", pass_cnt, 9);
      chk("mc_fail_cnt", fail_cnt, 27);
      chk("mc_fail_cnt_s", fail_cnt_s, 15);
      chk("mc_sticky", err_sticky, 4'b1110);
      mode = 0; clr_err = 1; sig = 0;
      tick(); clr_err = 0;
      chk("clr_sticky", err_sticky, 0);
      chk("clr_pass_cnt", pass_cnt, 0);
      chk("off_changed", changed, 4'b0001);
      mode = 8'h02;
      for (int k = 0; k < 4; k++) begin
         sig[0 +: W] = W'(k >= 2);
         tick();
         chk("stable_fail", fail[0], k == 2);
      end
      chk("stable_pass_cnt", pass_cnt, 3);
      chk("stable_fail_cnt", fail_cnt, 1);
      mode = 8'h03; clr_err = 1;
      for (int k = 1; k <= 16; k++) begin
         if (k % 4 == 0) sig[0 +: W] = ~sig[0 +: W];
         tick(); clr_err = 0;
      end
      chk("win4_pass_cnt", pass_cnt, 4);
      chk("win4_fail_cnt", fail_cnt, 0);
      clr_err = 1;
      for (int k = 1; k <= 20; k++) begin
         if (k % 5 == 0) sig[0 +: W] = ~sig[0 +: W];
         tick(); clr_err = 0;
         chk("win5_fail", fail[0], k % 5 == 4);
      end
      chk("win5_pass_cnt", pass_cnt, 4);
      chk("win5_fail_cnt", fail_cnt, 4);
      en = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("dis_fail", fail, 0);
      end
      en = 1; sig[0 +: W] = ~sig[0 +: W];
      tick();
      chk("reen_changed", changed, 0);
      chk("reen_fail", fail, 0);
      mode = 8'h01;
      tick(); tick();
      clr_err = 1;
      tick(); clr_err = 0;
      chk("clrfail_sticky", err_sticky, 4'b0001);
      chk("clrfail_cnt", fail_cnt, 1);
      chk("clrfail_cnt_s", fail_cnt_s, 1);
      mode = 8'h55; clr_err = 1;
      tick(); clr_err = 0;
      for (int k = 0; k < 4; k++) tick();
      chk("sat_fail_cnt", fail_cnt, 20);
      chk("sat_fail_cnt_s", fail_cnt_s, 15);
      rst = 1;
      tick(); rst = 0; sig = ~sig;
      tick();
      chk("rstmid_changed", changed, 0);
      chk("rstmid_fail", fail, 0);
      tick();
      chk("rstmid_fail2", fail, 4'hF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
